// File: rtl/display_arbiter.sv
// ---------------------------------------------------------------------------
// display_arbiter
//
// Time-shares the eight-digit seven-segment display between two requesters.
// Round-robin arbitration with a guaranteed minimum dwell. The selected
// owner's 32-bit digit word goes to the eight_display driver.
//
// Parameters:
//   DWELL      - minimum cycles an owner keeps the display while the other
//                side waits (>= 1)
//   IDLE_VALUE - digit word shown when nobody owns the display
//   GAP        - blank cycles between owners (>= 1), used only with the
//                optional feature below
//
// Optional feature (macro DISPLAY_ARB_GAP_EN):
//   An owner-to-owner switch passes through a blank GAP state for GAP
//   cycles. When the macro is undefined, switches are direct and no gap
//   logic is built.
//
// Ports:
//   ck      in   1   clock (only clock)
//   reset   in   1   synchronous, active-high reset
//   req     in   2   req[i] high while requester i wants the display
//   data0   in  32   requester 0 digits, [31:28] = digit 7 ... [3:0] = digit 0
//   data1   in  32   requester 1 digits, same layout
//   grant   out  2   one-hot owner, 2'b00 when unowned
//   digits  out 32   word to the display driver, [4k+3:4k] feeds digit k
//   valid   out  1   high when digits carries owner data
// ---------------------------------------------------------------------------
module display_arbiter #(
  parameter int unsigned DWELL      = 100000000,
  parameter logic [31:0] IDLE_VALUE = 32'h0000_0000,
  parameter int unsigned GAP        = 4
) (
  input  logic        ck,
  input  logic        reset,
  input  logic [1:0]  req,
  input  logic [31:0] data0,
  input  logic [31:0] data1,
  output logic [1:0]  grant,
  output logic [31:0] digits,
  output logic        valid
);

  localparam int unsigned CW = $clog2(DWELL + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DWELL - 1);

  // Reject illegal parameter values at elaboration time.
  if (DWELL < 1 || GAP < 1) begin : g_param_check
    $error("display_arbiter: DWELL and GAP must both be >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OWN0 = 2'd1,
    S_OWN1 = 2'd2
`ifdef DISPLAY_ARB_GAP_EN
    ,
    S_GAP  = 2'd3
`endif
  } state_t;

  state_t        state_q, state_d;
  logic          last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    grant_q, grant_d;
  logic [31:0]   digits_q, digits_d;
  logic          valid_q, valid_d;

`ifdef DISPLAY_ARB_GAP_EN
  localparam int unsigned GW = $clog2(GAP + 1);
  localparam logic [GW-1:0] GAP_MAX = GW'(GAP - 1);

  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic          target_q, target_d;
`endif

  logic dwell_done;
  logic cur;        // index of the current owner while in an OWN state
  logic take_own;   // enter an OWN state this cycle
  logic do_switch;  // owner-to-owner handover requested
  logic who;        // requester being handed the display

  assign dwell_done = (cnt_q == CNT_MAX);

  always_comb begin
    // NOTE: every signal gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    state_d   = state_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    take_own  = 1'b0;
    do_switch = 1'b0;
    who       = 1'b0;
    cur       = (state_q == S_OWN1);
`ifdef DISPLAY_ARB_GAP_EN
    gap_cnt_d = gap_cnt_q;
    target_d  = target_q;
`endif

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        unique case (req)
          2'b01:   begin take_own = 1'b1; who = 1'b0;    end
          2'b10:   begin take_own = 1'b1; who = 1'b1;    end
          2'b11:   begin take_own = 1'b1; who = ~last_q; end
          default: ;
        endcase
      end

      S_OWN0, S_OWN1: begin
        if (!req[cur]) begin
          // Owner released: hand over at once regardless of dwell.
          if (req[~cur]) begin
            do_switch = 1'b1;
            who       = ~cur;
          end else begin
            state_d = S_IDLE;
          end
        end else if (req[~cur] && dwell_done) begin
          do_switch = 1'b1;
          who       = ~cur;
        end else if (!dwell_done) begin
          // Saturate at DWELL-1 so a long uncontested tenure stays "done".
          cnt_d = cnt_q + CW'(1);
        end
      end

`ifdef DISPLAY_ARB_GAP_EN
      S_GAP: begin
        if (gap_cnt_q == GAP_MAX) begin
          if (req[target_q]) begin
            take_own = 1'b1;
            who      = target_q;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end
`endif

      default: state_d = S_IDLE;
    endcase

    if (do_switch) begin
`ifdef DISPLAY_ARB_GAP_EN
      // Latch the target now; it is re-qualified against req at GAP exit.
      state_d   = S_GAP;
      target_d  = who;
      gap_cnt_d = '0;
`else
      take_own  = 1'b1;
`endif
    end

    if (take_own) begin
      state_d = who ? S_OWN1 : S_OWN0;
      last_d  = who;
      cnt_d   = '0;
    end

    // Outputs are decoded from the next state so they register alongside it.
    grant_d  = {state_d == S_OWN1, state_d == S_OWN0};
    valid_d  = |grant_d;
    digits_d = (state_d == S_OWN0) ? data0 :
               (state_d == S_OWN1) ? data1 : IDLE_VALUE;
  end

  always_ff @(posedge ck) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q   <= S_IDLE;
      last_q    <= 1'b1;  // simultaneous first request goes to requester 0
      cnt_q     <= '0;
      grant_q   <= 2'b00;
      digits_q  <= IDLE_VALUE;
      valid_q   <= 1'b0;
`ifdef DISPLAY_ARB_GAP_EN
      gap_cnt_q <= '0;
      target_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      grant_q   <= grant_d;
      digits_q  <= digits_d;
      valid_q   <= valid_d;
`ifdef DISPLAY_ARB_GAP_EN
      gap_cnt_q <= gap_cnt_d;
      target_q  <= target_d;
`endif
    end
  end

  assign grant  = grant_q;
  assign digits = digits_q;
  assign valid  = valid_q;

endmodule
